seq_round_judge: RTL and testbench

Per-round judge for the memory-sequence game. On `start` it generates a pseudo-random sequence of `difficulty_k` symbols and plays it on the LEDs. It then checks the player's key presses against that sequence. It produces `round_clear` and `game_fail`, which feed the game-state register (round/difficulty/score tracker) directly downstream.

---
 rtl/seq_round_judge_pkg.sv | 31 +++
 rtl/seq_round_judge_if.sv | 27 ++
 rtl/seq_round_judge_lfsr16.sv | 21 ++
 rtl/seq_round_judge.sv | 153 +++++++++++++++
 tb/tb_seq_round_judge.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_round_judge_pkg.sv
// Shared constants for the memory-sequence round judge: symbol width, LFSR taps, FSM encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_judge_pkg;

   localparam int SYM_W   = 2;
   localparam int NUM_SYM = 1 << SYM_W;

   // Right-shifting Fibonacci form of taps 16,14,13,11: feedback is the XOR of
   // state bits 0,2,3,5 and enters at bit 15.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   typedef logic [2:0] state_t;
   localparam state_t IDLE  = 3'd0;
   localparam state_t GEN   = 3'd1;
   localparam state_t SHOW  = 3'd2;
   localparam state_t INPUT = 3'd3;
   localparam state_t CLEAR = 3'd4;
   localparam state_t FAIL  = 3'd5;

   // Requested round length forced into 1..max_k.
   function automatic int clamp_len(input int req, input int max_k);
      if (req <= 0)
         return 1;
      else if (req > max_k)
         return max_k;
      else
         return req;
   endfunction

endpackage

// File: rtl/seq_round_judge_if.sv
// Bundle between game-state logic (master) and the round judge (slave).
// Latency: n/a (wires only).
// Backpressure: none; start/key_valid are single-cycle pulses, outputs are levels/pulses.
interface seq_round_judge_if;

   logic                                     start;
   logic                                     abort;
   logic [3:0]                               difficulty_k;
   logic                                     key_valid;
   logic [seq_judge_pkg::SYM_W-1:0]          key_code;
   logic [seq_judge_pkg::NUM_SYM-1:0]        show_led;
   logic                                     busy;
   logic                                     input_phase;
   logic                                     round_clear;
   logic                                     game_fail;

   modport master (
      output start, abort, difficulty_k, key_valid, key_code,
      input  show_led, busy, input_phase, round_clear, game_fail
   );

   modport slave (
      input  start, abort, difficulty_k, key_valid, key_code,
      output show_led, busy, input_phase, round_clear, game_fail
   );

endinterface

// File: rtl/seq_round_judge_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; ports: clk, rst (async, active-high), state (current value).
// Latency: new value every cycle, reset loads SEED.
// Backpressure: none; steps unconditionally.
module lfsr16
   import seq_judge_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= SEED;
      else
         state <= {^(state & LFSR_TAPS), state[15:1]};
   end

endmodule

// File: rtl/seq_round_judge.sv
// Per-round judge: generates k random symbols, shows them on LEDs, then checks player keys.
// Latency: round_clear / game_fail appear the cycle after the deciding key (or timeout cycle).
// Backpressure: none; start while busy and keys outside INPUT are dropped.
// Ports: clk, rst (async active-high), bus (seq_round_judge_if.slave: start, abort,
// difficulty_k, key_valid, key_code in; show_led, busy, input_phase, round_clear, game_fail out).
module seq_round_judge
   import seq_judge_pkg::*;
#(
   parameter int          SHOW_TICKS    = 25_000_000,
   parameter int          GAP_TICKS     = 12_500_000,
   parameter int          TIMEOUT_TICKS = 250_000_000,
   parameter int          MAX_K         = 12,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   seq_round_judge_if.slave bus
);

   localparam int IDX_W  = $clog2(MAX_K + 1);
   localparam int TICK_W = $clog2(((SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS) + 1);
   localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [TICK_W-1:0] SHOW_LAST = TICK_W'(SHOW_TICKS - 1);
   localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

   state_t             state;
   logic [IDX_W-1:0]   len;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   last_idx;
   logic [TICK_W-1:0]  tick;
   logic               gap;       // 0: symbol lit, 1: dark gap after it
   logic [TO_W-1:0]    to_cnt;
   logic               fail_q;
   logic [SYM_W-1:0]   pattern [MAX_K];
   logic [15:0]        lfsr;
   logic               lfsr_unused;
   logic               key_hit;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr)
   );

   assign lfsr_unused = ^lfsr[15:SYM_W];
   assign last_idx    = len - 1'b1;
   assign key_hit     = (bus.key_code == pattern[idx]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         len    <= '0;
         idx    <= '0;
         tick   <= '0;
         gap    <= 1'b0;
         to_cnt <= '0;
         fail_q <= 1'b0;
      end else if (bus.abort) begin
         state  <= IDLE;
         idx    <= '0;
         tick   <= '0;
         gap    <= 1'b0;
         to_cnt <= '0;
         fail_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  len    <= IDX_W'(clamp_len(int'(bus.difficulty_k), MAX_K));
                  idx    <= '0;
                  fail_q <= 1'b0;
                  state  <= GEN;
               end
            end
            GEN: begin
               if (idx == last_idx) begin
                  idx   <= '0;
                  tick  <= '0;
                  gap   <= 1'b0;
                  state <= SHOW;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            SHOW: begin
               if (!gap) begin
                  if (tick == SHOW_LAST) begin
                     tick <= '0;
                     gap  <= 1'b1;
                  end else begin
                     tick <= tick + 1'b1;
                  end
               end else if (tick == GAP_LAST) begin
                  tick <= '0;
                  gap  <= 1'b0;
                  if (idx == last_idx) begin
                     idx    <= '0;
                     to_cnt <= '0;
                     state  <= INPUT;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            INPUT: begin
               // A key arriving on the expiry cycle is judged instead of timing out.
               if (bus.key_valid) begin
                  if (!key_hit) begin
                     fail_q <= 1'b1;
                     state  <= FAIL;
                  end else if (idx == last_idx) begin
                     state <= CLEAR;
                  end else begin
                     idx    <= idx + 1'b1;
                     to_cnt <= '0;
                  end
               end else if (to_cnt == TO_LAST) begin
                  fail_q <= 1'b1;
                  state  <= FAIL;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            CLEAR:   state <= IDLE;
            FAIL:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Pattern storage needs no reset: every entry read in a round is written in GEN first.
   always_ff @(posedge clk) begin
      if (state == GEN && !bus.abort)
         pattern[idx] <= lfsr[SYM_W-1:0];
   end

   always_comb begin
      bus.show_led = '0;
      if (state == SHOW && !gap)
         bus.show_led[pattern[idx]] = 1'b1;
   end

   assign bus.busy        = (state != IDLE);
   assign bus.input_phase = (state == INPUT);
   // abort in the CLEAR cycle still suppresses the success pulse.
   assign bus.round_clear = (state == CLEAR) && !bus.abort;
   assign bus.game_fail   = fail_q;

endmodule

// File: tb/tb_seq_round_judge.sv
// Self-checking bench for seq_round_judge with short show/gap/timeout parameters.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_seq_round_judge;
   import seq_judge_pkg::*;

   localparam int SHOW_T = 4;
   localparam int GAP_T  = 2;
   localparam int TO_T   = 20;
   localparam int MAXK   = 12;

   localparam int MODE_CLEAR   = 0;
   localparam int MODE_WRONG   = 1;
   localparam int MODE_TIMEOUT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seq_round_judge_if bus ();

   seq_round_judge #(
      .SHOW_TICKS    (SHOW_T),
      .GAP_TICKS     (GAP_T),
      .TIMEOUT_TICKS (TO_T),
      .MAX_K         (MAXK),
      .LFSR_SEED     (16'hACE1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, shifting right.
   logic [15:0] m_lfsr;
   always @(posedge clk or posedge rst) begin
      if (rst)
         m_lfsr <= 16'hACE1;
      else
         m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   int n_tests = 0;
   int n_fail  = 0;
   bit fail_lvl = 1'b0;

   logic [1:0] exp_q [$];   // symbols predicted while GEN runs
   logic [1:0] shown [$];   // symbols confirmed on the LEDs, replayed as keys

   typedef struct {
      int dk;
      int exp_k;
      int mode;
      int bad;
      bit glitch;
   } round_t;

   round_t rounds [7];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Starts a round and walks GEN and SHOW; leaves the bench in INPUT cycle 1.
   task automatic start_round(input int dk, input int exp_k, input bit glitch);
      logic [1:0] sym;
      chk("busy_before_start", int'(bus.busy), 0);
      chk("fail_level_before_start", int'(bus.game_fail), int'(fail_lvl));
      bus.difficulty_k = 4'(dk);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("busy_after_start", int'(bus.busy), 1);
      chk("fail_cleared_by_start", int'(bus.game_fail), 0);
      fail_lvl = 1'b0;
      exp_q.delete();
      shown.delete();
      for (int g = 0; g < exp_k; g++) begin
         chk("gen_led_dark", int'(bus.show_led), 0);
         exp_q.push_back(m_lfsr[1:0]);
         if (glitch && g == 0) begin
            bus.key_valid = 1'b1;
            bus.key_code  = ~m_lfsr[1:0];
         end
         tick();
         bus.key_valid = 1'b0;
      end
      for (int s = 0; s < exp_k; s++) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
            sym = 2'd0;
         end else begin
            sym = exp_q.pop_front();
         end
         shown.push_back(sym);
         for (int t = 0; t < SHOW_T; t++) begin
            chk("show_led_symbol", int'(bus.show_led), 1 << sym);
            if (glitch && s == 1 && t == 1) begin
               bus.difficulty_k = 4'd2;
               bus.start        = 1'b1;
               bus.key_valid    = 1'b1;
               bus.key_code     = sym + 2'd1;
            end
            tick();
            bus.start     = 1'b0;
            bus.key_valid = 1'b0;
         end
         for (int t = 0; t < GAP_T; t++) begin
            chk("gap_led_dark", int'(bus.show_led), 0);
            chk("no_input_during_show", int'(bus.input_phase), 0);
            tick();
         end
      end
      chk("input_phase_up", int'(bus.input_phase), 1);
      chk("leftover_symbols", exp_q.size(), 0);
   endtask

   task automatic play_keys(input int mode, input int bad);
      logic [1:0] code;
      if (mode == MODE_TIMEOUT) begin
         for (int c = 1; c <= TO_T; c++) begin
            chk("no_fail_before_timeout", int'(bus.game_fail), 0);
            tick();
         end
         chk("fail_on_timeout", int'(bus.game_fail), 1);
         chk("no_clear_on_timeout", int'(bus.round_clear), 0);
         tick();
         chk("idle_after_timeout", int'(bus.busy), 0);
         fail_lvl = 1'b1;
         return;
      end
      for (int j = 0; j < shown.size(); j++) begin
         code = shown[j];
         if (mode == MODE_WRONG && j == bad)
            code = code ^ 2'd1;
         bus.key_valid = 1'b1;
         bus.key_code  = code;
         tick();
         bus.key_valid = 1'b0;
         if (mode == MODE_WRONG && j == bad) begin
            chk("fail_after_bad_key", int'(bus.game_fail), 1);
            chk("no_clear_on_fail", int'(bus.round_clear), 0);
            tick();
            chk("idle_after_fail", int'(bus.busy), 0);
            repeat (3) tick();
            chk("fail_held", int'(bus.game_fail), 1);
            chk("no_late_clear", int'(bus.round_clear), 0);
            fail_lvl = 1'b1;
            return;
         end
         if (j == shown.size() - 1) begin
            chk("clear_pulse", int'(bus.round_clear), 1);
            chk("no_fail_on_clear", int'(bus.game_fail), 0);
            tick();
            chk("clear_one_cycle", int'(bus.round_clear), 0);
            chk("idle_after_clear", int'(bus.busy), 0);
            chk("fail_low_after_clear", int'(bus.game_fail), 0);
            return;
         end
         chk("still_input", int'(bus.input_phase), 1);
         chk("no_early_clear", int'(bus.round_clear), 0);
         tick();
         tick();
      end
   endtask

   initial begin
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.difficulty_k = 4'd0;
      bus.key_valid    = 1'b0;
      bus.key_code     = 2'd0;

      rounds[0] = '{4, 4, MODE_CLEAR, 0, 1'b0};
      rounds[1] = '{4, 4, MODE_WRONG, 1, 1'b0};
      rounds[2] = '{4, 4, MODE_TIMEOUT, 0, 1'b0};
      rounds[3] = '{0, 1, MODE_CLEAR, 0, 1'b0};
      rounds[4] = '{15, 12, MODE_CLEAR, 0, 1'b1};
      rounds[5] = '{7, 7, MODE_WRONG, 0, 1'b0};
      rounds[6] = '{13, 12, MODE_WRONG, 11, 1'b0};

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("rst_show_led", int'(bus.show_led), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_input_phase", int'(bus.input_phase), 0);
      chk("rst_round_clear", int'(bus.round_clear), 0);
      chk("rst_game_fail", int'(bus.game_fail), 0);
      tick();

      for (int i = 0; i < 7; i++) begin
         start_round(rounds[i].dk, rounds[i].exp_k, rounds[i].glitch);
         play_keys(rounds[i].mode, rounds[i].bad);
         tick();
      end

      // abort clears a held game_fail while idle
      chk("fail_held_before_abort", int'(bus.game_fail), 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_clears_fail", int'(bus.game_fail), 0);
      fail_lvl = 1'b0;
      tick();

      // key landing on the last timeout cycle is judged, not timed out
      start_round(1, 1, 1'b0);
      repeat (TO_T - 1) tick();
      chk("still_waiting_cycle20", int'(bus.game_fail), 0);
      bus.key_valid = 1'b1;
      bus.key_code  = shown[0];
      tick();
      bus.key_valid = 1'b0;
      chk("key_at_expiry_clears", int'(bus.round_clear), 1);
      chk("key_at_expiry_no_fail", int'(bus.game_fail), 0);
      tick();

      // abort in the middle of SHOW
      bus.difficulty_k = 4'd3;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (3 + 2) tick();
      chk("lit_before_abort", int'(bus.show_led != 0), 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_show_led", int'(bus.show_led), 0);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_game_fail", int'(bus.game_fail), 0);
      chk("abort_round_clear", int'(bus.round_clear), 0);
      repeat (4) tick();
      chk("abort_stays_idle", int'(bus.busy), 0);

      // abort together with the winning key: no success pulse
      start_round(1, 1, 1'b0);
      bus.key_valid = 1'b1;
      bus.key_code  = shown[0];
      bus.abort     = 1'b1;
      tick();
      bus.key_valid = 1'b0;
      bus.abort     = 1'b0;
      chk("abort_beats_clear", int'(bus.round_clear), 0);
      chk("abort_beats_clear_busy", int'(bus.busy), 0);
      tick();
      chk("no_clear_after_abort", int'(bus.round_clear), 0);

      // rst in the middle of INPUT
      start_round(2, 2, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", int'(bus.busy), 0);
      chk("rst_mid_input_phase", int'(bus.input_phase), 0);
      chk("rst_mid_show_led", int'(bus.show_led), 0);
      chk("rst_mid_game_fail", int'(bus.game_fail), 0);
      chk("rst_mid_round_clear", int'(bus.round_clear), 0);
      tick();
      rst = 1'b0;
      tick();

      // full round after reset; LFSR restarts from the seed
      start_round(3, 3, 1'b0);
      play_keys(MODE_CLEAR, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
